// File: rtl/ssp_tx_fifo_if.sv
// Bus bundle between the write port / shifter side and the transmit FIFO.
// The master side drives the write strobe, write data and shifter pop request.
// The slave side (the FIFO) returns the head word and the status flags.
interface ssp_tx_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     psel;
    logic                     pwrite;
    logic [WIDTH-1:0]         pwdata;
    logic                     t_en;
    logic [WIDTH-1:0]         txdata;
    logic                     ready;
    logic                     ssptxintr;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    modport master (
        output psel, pwrite, pwdata, t_en,
        input  txdata, ready, ssptxintr, level, overflow
    );

    modport slave (
        input  psel, pwrite, pwdata, t_en,
        output txdata, ready, ssptxintr, level, overflow
    );
endinterface

// File: rtl/ssp_tx_fifo.sv
// Transmit FIFO feeding the SSP shifter.
// Words arrive on psel&pwrite, the head word is presented first-word
// fall-through on txdata, and each rising edge of t_en pops one word.
// Status: ready (not empty), level, ssptxintr (full), sticky overflow.
module ssp_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic               pclk,
    input  logic               clear_b,
    ssp_tx_fifo_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_t_en_d;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_req;
    logic             w_pop;
    logic             w_push;
    logic             w_wr_req;
    logic             w_rd_acc;

    // Occupancy flags and push/pop qualification; a pop in the same cycle
    // frees a slot, so a write into a full FIFO is accepted alongside it.
    always_comb begin
        w_full    = (r_level == FULL_LVL);
        w_empty   = (r_level == '0);
        w_wr_req  = bus.psel & bus.pwrite;
        w_rd_acc  = bus.psel & ~bus.pwrite;
        w_pop_req = bus.t_en & ~r_t_en_d;
        w_pop     = w_pop_req & ~w_empty;
        w_push    = w_wr_req & (~w_full | w_pop);
    end

    // Delayed copy of t_en so a long t_en pulse yields a single pop.
    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) r_t_en_d <= 1'b0;
        else          r_t_en_d <= bus.t_en;
    end

    // Storage is deliberately left out of reset; only pointers decide validity.
    always_ff @(posedge pclk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.pwdata;
    end

    // Write pointer advances on every accepted word, wrapping naturally.
    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b)    r_wr_ptr <= '0;
        else if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
    end

    // Read pointer advances on every honoured pop.
    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b)   r_rd_ptr <= '0;
        else if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end

    // Occupancy counter kept separately from the pointers so full and empty
    // are unambiguous when the pointers are equal.
    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b)                r_level <= '0;
        else if (w_push && !w_pop)   r_level <= r_level + LW'(1);
        else if (w_pop && !w_push)   r_level <= r_level - LW'(1);
    end

    // Sticky overflow: a dropped write sets it, a read access clears it,
    // and a set in the same cycle as a clear wins.
    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b)                          r_overflow <= 1'b0;
        else if (w_wr_req && w_full && !w_pop) r_overflow <= 1'b1;
        else if (w_rd_acc)                     r_overflow <= 1'b0;
    end

    // Outputs decoded only from registered state so they never glitch on
    // write-port activity; txdata reads zero whenever the FIFO is empty.
    always_comb begin
        bus.txdata    = w_empty ? '0 : r_mem[r_rd_ptr];
        bus.ready     = ~w_empty;
        bus.ssptxintr = w_full;
        bus.level     = r_level;
        bus.overflow  = r_overflow;
    end
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed bench for ssp_tx_fifo: stimulus pushes expected pop data into a
// scoreboard queue; a monitor compares txdata whenever a pop is presented.
module tb_ssp_tx_fifo;
    logic pclk;
    logic clear_b;
    int   errors;
    int   checks;
    logic [7:0] sb_q [$];
    logic       tb_tend;

    ssp_tx_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    ssp_tx_fifo #(.DEPTH(4), .WIDTH(8)) dut (
        .pclk    (pclk),
        .clear_b (clear_b),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench-side t_en delay, used only to locate pop cycles for the monitor.
    always @(posedge pclk or negedge clear_b) begin
        if (!clear_b) tb_tend <= 1'b0;
        else          tb_tend <= bus.t_en;
    end

    // Monitor: in the middle of a cycle where a pop will be taken, the head
    // word on txdata must be the oldest word the stimulus expected to queue.
    always @(negedge pclk) begin
        if (clear_b && bus.t_en && !tb_tend && bus.ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %0h expected no pop (queue empty)", bus.txdata);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (bus.txdata !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", bus.txdata, e);
                end
            end
        end
    end

    // One clock of stimulus; acc says whether the write should be stored.
    task automatic step(input bit w, input bit r, input logic [7:0] d, input bit te, input bit acc);
        bus.psel   = w | r;
        bus.pwrite = w;
        bus.pwdata = d;
        bus.t_en   = te;
        if (w && acc) sb_q.push_back(d);
        @(posedge pclk);
        #1;
        bus.psel   = 1'b0;
        bus.pwrite = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.psel = 1'b0; bus.pwrite = 1'b0; bus.pwdata = 8'h00; bus.t_en = 1'b0;
        clear_b = 1'b0;
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_txdata", bus.txdata, 0);
        chk("rst_intr", bus.ssptxintr, 0);
        chk("rst_ovf", bus.overflow, 0);
        @(posedge pclk); #1;
        clear_b = 1'b1;
        idle();

        // Single word round trip
        step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
        chk("t2_ready", bus.ready, 1);
        chk("t2_level", bus.level, 1);
        chk("t2_txdata", bus.txdata, 8'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_level0", bus.level, 0);
        chk("t2_ready0", bus.ready, 0);
        chk("t2_txdata0", bus.txdata, 0);
        idle();

        // Fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
        chk("t3_level4", bus.level, 4);
        chk("t3_intr", bus.ssptxintr, 1);
        chk("t3_ovf0", bus.overflow, 0);
        step(1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
        chk("t3_ovf1", bus.overflow, 1);
        chk("t3_level_ovf", bus.level, 4);
        chk("t3_head", bus.txdata, 8'h01);
        for (int i = 0; i < 4; i++) pop1();
        chk("t3_empty", bus.ready, 0);
        chk("t3_intr0", bus.ssptxintr, 0);
        chk("t3_ovf_sticky", bus.overflow, 1);

        // Read access clears overflow; repeated dropped writes keep it set
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t6_clr", bus.overflow, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h14, 1'b0, 1'b0);
        chk("t6_set", bus.overflow, 1);
        step(1'b1, 1'b0, 8'h15, 1'b0, 1'b0);
        chk("t6_hold", bus.overflow, 1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t6_clr2", bus.overflow, 0);

        // Write while full with coincident pop
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
        chk("t5_level", bus.level, 4);
        chk("t5_ovf", bus.overflow, 0);
        chk("t5_head", bus.txdata, 8'h11);
        idle();
        for (int i = 0; i < 4; i++) pop1();
        chk("t5_empty", bus.level, 0);

        // Long t_en pulse pops exactly once
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h21 + 8'(i), 1'b0, 1'b1);
        chk("t4_level3", bus.level, 3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_level2", bus.level, 2);
        idle();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_level1", bus.level, 1);
        idle();
        pop1();
        chk("t4_empty", bus.level, 0);

        // Push into empty with coincident pop request: only push takes effect
        step(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
        chk("emp_pp_level", bus.level, 1);
        chk("emp_pp_data", bus.txdata, 8'h5A);
        idle();
        pop1();

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0, 1'b1);
            chk("wrap_lvl1", bus.level, 1);
            pop1();
            chk("wrap_lvl0", bus.level, 0);
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b1);
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.pwdata = 8'h43;
        #2;
        clear_b = 1'b0;
        #1;
        chk("arst_ready", bus.ready, 0);
        chk("arst_level", bus.level, 0);
        chk("arst_txdata", bus.txdata, 0);
        chk("arst_intr", bus.ssptxintr, 0);
        chk("arst_ovf", bus.overflow, 0);
        bus.psel = 1'b0; bus.pwrite = 1'b0;
        sb_q.delete();
        @(posedge pclk); #1;
        clear_b = 1'b1;
        idle();
        chk("post_rst_level", bus.level, 0);
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        chk("post_rst_data", bus.txdata, 8'h77);
        pop1();
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
